nf_imm_ctrl: RTL and testbench

NF_IMM_CTRL -- requirements
Module: nf_imm_ctrl

---
 rtl/nf_cpu_pkg.sv | 42 ++++
 rtl/nf_sign_ex.sv | 21 ++
 rtl/nf_imm_ctrl.sv | 133 +++++++++++++
 tb/tb_nf_imm_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf_cpu_pkg.sv
// nf_cpu_pkg -- shared RV32I decode constants and types.
//   IMM_* : immediate class encodings carried on imm_src (i/u/b/s)
//   OP_*  : RV32I major opcodes that carry an immediate
//   imm_entry_t : one buffered decode result
//   decode_op() : opcode -> {illegal, imm_src}
package nf_cpu_pkg;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_U = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;
  localparam logic [1:0] IMM_S = 2'd3;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef struct packed {
    logic [31:0] imm;
    logic [1:0]  imm_src;
    logic [31:0] pc;
    logic        illegal;
  } imm_entry_t;

  // Returns {illegal, imm_src}. Opcodes without an immediate report class i.
  function automatic logic [2:0] decode_op(input logic [6:0] op);
    logic [2:0] res;
    res = {1'b0, IMM_I};
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: res = {1'b0, IMM_I};
      OP_LUI, OP_AUIPC:         res = {1'b0, IMM_U};
      OP_BRANCH:                res = {1'b0, IMM_B};
      OP_STORE:                 res = {1'b0, IMM_S};
      default:                  res = {1'b1, IMM_I};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/nf_sign_ex.sv
// nf_sign_ex -- immediate extension.
//   raw_i     : 20-bit raw field; i/b/s use the low 12 bits, u uses all 20
//   imm_src_i : immediate class
//   imm_o     : 32-bit extended immediate (u is zero-extended, not shifted)
module nf_sign_ex
  import nf_cpu_pkg::*;
(
  input  logic [19:0] raw_i,
  input  logic [1:0]  imm_src_i,
  output logic [31:0] imm_o
);

  always_comb begin
    if (imm_src_i == IMM_U) begin
      imm_o = {12'h000, raw_i};
    end else begin
      imm_o = {{20{raw_i[11]}}, raw_i[11:0]};
    end
  end

endmodule

// File: rtl/nf_imm_ctrl.sv
// nf_imm_ctrl -- RV32I immediate decode feeding a 2-entry in-order FIFO.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake, instr_i + pc_i payload
//   flush               : drop all buffered entries and any same-cycle input
//   out_valid/out_ready : downstream handshake on the head entry
//   imm_o, imm_src_o, pc_o, illegal_o : head entry, zero when out_valid is low
//   illegal_cnt         : saturating count of accepted illegal-opcode entries
module nf_imm_ctrl
  import nf_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] imm_o,
  output logic [1:0]  imm_src_o,
  output logic [31:0] pc_o,
  output logic        illegal_o,
  output logic [7:0]  illegal_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [2:0]  dec;
  logic        in_illegal;
  logic [1:0]  in_src;
  logic [19:0] raw_field;
  logic [31:0] ext_imm;
  imm_entry_t  new_entry;

  logic [1:0]  state_q, state_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [7:0]  illegal_cnt_q, illegal_cnt_d;
  imm_entry_t  slot_q [2];
  imm_entry_t  head;

  logic        push, pop;

  // Combinational decode of the incoming word; only the result is stored.
  always_comb begin
    dec        = decode_op(instr_i[6:0]);
    in_illegal = dec[2];
    in_src     = dec[1:0];
    raw_field  = 20'h00000;
    if (!in_illegal) begin
      case (in_src)
        IMM_I:   raw_field = {8'h00, instr_i[31:20]};
        IMM_U:   raw_field = instr_i[31:12];
        IMM_B:   raw_field = {8'h00, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]};
        IMM_S:   raw_field = {8'h00, instr_i[31:25], instr_i[11:7]};
        default: raw_field = 20'h00000;
      endcase
    end
  end

  nf_sign_ex u_sign_ex (
    .raw_i     (raw_field),
    .imm_src_i (in_src),
    .imm_o     (ext_imm)
  );

  always_comb begin
    new_entry.imm     = ext_imm;
    new_entry.imm_src = in_src;
    new_entry.pc      = pc_i;
    new_entry.illegal = in_illegal;
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    illegal_cnt_d = illegal_cnt_q;
    if (flush) begin
      state_d  = EMPTY;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case (state_q)
        EMPTY:   if (push) state_d = ONE;
        ONE:     if (push && !pop) state_d = TWO;
                 else if (pop && !push) state_d = EMPTY;
        TWO:     if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
      if (push && in_illegal && (illegal_cnt_q != 8'hFF)) begin
        illegal_cnt_d = illegal_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      illegal_cnt_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Slot contents need no reset: they are only observed through out_valid.
  always_ff @(posedge clk) begin
    if (push) slot_q[wr_ptr_q] <= new_entry;
  end

  assign head        = slot_q[rd_ptr_q];
  assign imm_o       = out_valid ? head.imm     : 32'h0;
  assign imm_src_o   = out_valid ? head.imm_src : 2'b00;
  assign pc_o        = out_valid ? head.pc      : 32'h0;
  assign illegal_o   = out_valid ? head.illegal : 1'b0;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_nf_imm_ctrl.sv
module tb_nf_imm_ctrl;

  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_U = 2'd1;
  localparam logic [1:0] S_B = 2'd2;
  localparam logic [1:0] S_S = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr_i = 32'h0;
  logic [31:0] pc_i = 32'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm_o;
  logic [1:0]  imm_src_o;
  logic [31:0] pc_o;
  logic        illegal_o;
  logic [7:0]  illegal_cnt;

  logic        rand_rdy = 1'b0;
  logic        forced_rdy = 1'b0;
  logic        rnd_q = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] imm;
    logic [1:0]  src;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   model_cnt = 0;

  nf_imm_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr_i     (instr_i),
    .pc_i        (pc_i),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .imm_o       (imm_o),
    .imm_src_o   (imm_src_o),
    .pc_o        (pc_o),
    .illegal_o   (illegal_o),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rnd_q <= 1'($urandom_range(0, 1));
  assign out_ready = rand_rdy ? rnd_q : forced_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx12(input logic [11:0] f);
    int v;
    v = int'(f);
    if (v >= 2048) v = v - 4096;
    return v;
  endfunction

  // Reference: decode straight from the RV32I immediate rules.
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ill = 1'b0;
    e.src = S_I;
    e.imm = 32'h0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin
        e.src = S_I;
        e.imm = 32'(sx12(ins[31:20]));
      end
      7'h37, 7'h17: begin
        e.src = S_U;
        e.imm = 32'(int'(ins[31:12]));
      end
      7'h63: begin
        e.src = S_B;
        e.imm = 32'(sx12({ins[31], ins[7], ins[30:25], ins[11:8]}));
      end
      7'h23: begin
        e.src = S_S;
        e.imm = 32'(sx12({ins[31:25], ins[11:7]}));
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Scoreboard monitor: compares the DUT against the queue model every cycle.
  always @(negedge clk) begin
    int   sz;
    exp_t e;
    if (rst) begin
      q.delete();
      model_cnt = 0;
    end else begin
      sz = q.size();
      check("in_ready", in_ready, sz < 2);
      check("out_valid", out_valid, sz > 0);
      check("illegal_cnt", illegal_cnt, model_cnt);
      if (sz > 0) begin
        check("imm_o", imm_o, q[0].imm);
        check("imm_src_o", imm_src_o, q[0].src);
        check("pc_o", pc_o, q[0].pc);
        check("illegal_o", illegal_o, q[0].ill);
      end else begin
        check("imm_o_idle", imm_o, 0);
        check("imm_src_o_idle", imm_src_o, 0);
        check("pc_o_idle", pc_o, 0);
        check("illegal_o_idle", illegal_o, 0);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (sz > 0 && out_ready) void'(q.pop_front());
        if (in_valid && sz < 2) begin
          e = ref_model(instr_i, pc_i);
          q.push_back(e);
          if (e.ill && model_cnt < 255) model_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    instr_i  = ins;
    pc_i     = pc;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !flush) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready never high for pc %h", pc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input logic [31:0] ins, input logic [31:0] exp_imm,
                          input logic [1:0] exp_src, input string name);
    forced_rdy = 1'b0;
    send(ins, 32'h1000);
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_imm"}, imm_o, exp_imm);
    check({name, "_src"}, imm_src_o, exp_src);
    @(posedge clk); #1;
    forced_rdy = 1'b1;
    @(posedge clk); #1;
    forced_rdy = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    rand_rdy   = 1'b0;
    forced_rdy = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!out_valid) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: out_valid stuck high");
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [6:0] ops [7] = '{7'h03, 7'h13, 7'h67, 7'h37, 7'h17, 7'h63, 7'h23};

  initial begin
    logic [31:0] w;
    int          r;
    logic [31:0] pc_ctr;
    pc_ctr = 32'h2000;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_illegal_cnt", illegal_cnt, 0);
    check("rst_imm_o", imm_o, 0);
    @(posedge clk); #1;

    directed(32'hFFF00093, 32'hFFFFFFFF, S_I, "addi");
    directed(32'h123450B7, 32'h00012345, S_U, "lui");
    directed(32'h80000063, 32'hFFFFF800, S_B, "beq");
    directed(32'hFE112E23, 32'hFFFFFFFC, S_S, "sw");

    // Back-to-back pushes against a stalled consumer.
    forced_rdy = 1'b0;
    send(32'h00100093, 32'hA0);
    send(32'h00200113, 32'hA4);
    fork
      send(32'h00300193, 32'hA8);
      begin
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        check("held_in_ready", in_ready, 0);
        @(posedge clk); #1;
        forced_rdy = 1'b1;
      end
    join
    drain();

    // Flush while full with a concurrent input.
    forced_rdy = 1'b0;
    send(32'h00500293, 32'hB0);
    send(32'h00600313, 32'hB4);
    in_valid = 1'b1;
    instr_i  = 32'h00700393;
    pc_i     = 32'hB8;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;

    // Illegal-opcode counter saturation.
    forced_rdy = 1'b1;
    for (int i = 0; i < 260; i++) send(32'h00000000, 32'h4000 + 32'(i));
    @(negedge clk);
    check("sat_illegal_cnt", illegal_cnt, 255);
    drain();

    // Reset mid-operation discards entries and clears the counter.
    forced_rdy = 1'b0;
    send(32'h00000000, 32'hC0);
    send(32'h00800413, 32'hC4);
    pulse_rst();
    @(negedge clk);
    check("rst2_illegal_cnt", illegal_cnt, 0);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Randomized traffic with random back-pressure and occasional flushes.
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      w = $urandom();
      if ($urandom_range(0, 7) != 7) w[6:0] = ops[$urandom_range(0, 6)];
      if (r == 0) begin
        in_valid = 1'($urandom_range(0, 1));
        instr_i  = w;
        pc_i     = pc_ctr;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
      end else if (r < 5) begin
        @(posedge clk); #1;
      end else begin
        send(w, pc_ctr);
      end
      pc_ctr = pc_ctr + 32'd4;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
